// File: rtl/shim_trigger_pkg.sv
// Shared definitions for the trigger core and its timestamp reader:
// FIFO/timestamp widths, lockout constant, reader FSM encoding and helpers.
package shim_trigger_pkg;

  localparam int FIFO_WORD_W      = 32;
  localparam int TS_W             = 64;
  localparam int TRIG_COUNT_W     = 32;
  // Minimum cycles between triggers on the writer side; the reader needs
  // exactly this many cycles per timestamp, so the FIFO cannot grow.
  localparam int TRIG_LOCKOUT_MIN = 4;

  // Reader FSM encoding (kept as plain constants for legacy tools).
  typedef logic [2:0] state_t;
  localparam state_t S_LO      = 3'd0;
  localparam state_t S_LO_CAP  = 3'd1;
  localparam state_t S_HI_WAIT = 3'd2;
  localparam state_t S_HI_CAP  = 3'd3;
  localparam state_t S_OUT     = 3'd4;
  localparam state_t S_ERROR   = 3'd5;

  // Saturating increment for the trigger counter.
  function automatic logic [TRIG_COUNT_W-1:0] sat_inc(input logic [TRIG_COUNT_W-1:0] v);
    if (v == {TRIG_COUNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + TRIG_COUNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/shim_trigger_ts_reader_if.sv
// Timestamp output stream: valid/ready handshake plus payload and count.
interface shim_trigger_ts_reader_if #(
  parameter int DELTA_WIDTH = 32
);
  import shim_trigger_pkg::*;

  logic                    ts_valid;
  logic                    ts_ready;
  logic [TS_W-1:0]         ts;
  logic [DELTA_WIDTH-1:0]  ts_delta;
  logic                    ts_first;
  logic [TRIG_COUNT_W-1:0] trig_count;

  modport master (
    output ts_valid, ts, ts_delta, ts_first, trig_count,
    input  ts_ready
  );

  modport slave (
    input  ts_valid, ts, ts_delta, ts_first, trig_count,
    output ts_ready
  );

endinterface

// File: rtl/shim_ts_delta.sv
// Registered interval computation: cur - prev, clamped to the delta width,
// forced to zero for the first timestamp or when time runs backwards.
// A one-cycle order pulse flags the backwards case.
module shim_ts_delta
  import shim_trigger_pkg::*;
#(
  parameter int DELTA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   first,
  input  logic [TS_W-1:0]        cur,
  input  logic [TS_W-1:0]        prev,
  output logic [DELTA_WIDTH-1:0] delta,
  output logic                   order_pulse
);

  localparam logic [TS_W-1:0] DELTA_MAX = {TS_W{1'b1}} >> (TS_W - DELTA_WIDTH);

  logic [TS_W-1:0] diff;
  logic [TS_W-1:0] clamped;
  logic            behind;

  // Difference, ordering and saturation of the candidate timestamp.
  always_comb begin
    diff   = cur - prev;
    behind = (cur < prev);
    if (first || behind) begin
      clamped = {TS_W{1'b0}};
    end else if (diff > DELTA_MAX) begin
      clamped = DELTA_MAX;
    end else begin
      clamped = diff;
    end
  end

  // Register the delta alongside the timestamp capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delta       <= {DELTA_WIDTH{1'b0}};
      order_pulse <= 1'b0;
    end else begin
      order_pulse <= en && !first && behind;
      if (en) begin
        delta <= clamped[DELTA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/shim_trigger_ts_reader.sv
// Drains the non-FWFT trigger timestamp FIFO, pairs low/high words into a
// 64-bit timestamp and presents it with interval, first flag and count.
module shim_trigger_ts_reader
  import shim_trigger_pkg::*;
#(
  parameter int PAIR_TIMEOUT = 16,
  parameter int DELTA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   data_word_rd_en,
  input  logic [FIFO_WORD_W-1:0] data_word,
  input  logic                   data_buf_empty,
  input  logic                   flush,
  shim_trigger_ts_reader_if.master ts_out,
  output logic                   pair_timeout,
  output logic                   order_err
);

  localparam int TMR_W = (PAIR_TIMEOUT < 2) ? 1 : $clog2(PAIR_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAIR_TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    rd_en;
  logic [TMR_W-1:0]        timer;
  logic [FIFO_WORD_W-1:0]  lo_word;
  logic [TS_W-1:0]         ts_reg;
  logic                    ts_first_reg;
  logic                    first_pend;
  logic [TS_W-1:0]         prev_ts;
  logic [TRIG_COUNT_W-1:0] trig_count;
  logic [DELTA_WIDTH-1:0]  delta;
  logic                    order_pulse;
  logic                    hs;
  logic                    hi_cap;
  logic                    hi_expire;

  assign hs        = (state == S_OUT) && ts_out.ts_ready && !flush;
  assign hi_cap    = (state == S_HI_CAP) && !flush;
  assign hi_expire = (state == S_HI_WAIT) && data_buf_empty && (timer == TMR_LAST);

  // Next-state and read-strobe decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    if (flush) begin
      state_nxt = S_LO;
    end else begin
      case (state)
        S_LO: begin
          if (!data_buf_empty) begin
            rd_en     = 1'b1;
            state_nxt = S_LO_CAP;
          end else begin
            state_nxt = S_LO;
          end
        end
        S_LO_CAP: begin
          if (!data_buf_empty) begin
            rd_en     = 1'b1;
            state_nxt = S_HI_CAP;
          end else begin
            state_nxt = S_HI_WAIT;
          end
        end
        S_HI_WAIT: begin
          if (!data_buf_empty) begin
            rd_en     = 1'b1;
            state_nxt = S_HI_CAP;
          end else if (timer == TMR_LAST) begin
            state_nxt = S_ERROR;
          end else begin
            state_nxt = S_HI_WAIT;
          end
        end
        S_HI_CAP: state_nxt = S_OUT;
        S_OUT: begin
          if (ts_out.ts_ready) begin
            state_nxt = S_LO;
          end else begin
            state_nxt = S_OUT;
          end
        end
        S_ERROR:  state_nxt = S_ERROR;
        default:  state_nxt = S_LO;
      endcase
    end
  end

  assign data_word_rd_en = rd_en;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // High-word wait timer, restarted whenever a low word is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= {TMR_W{1'b0}};
    end else if (flush || (state == S_LO_CAP)) begin
      timer <= {TMR_W{1'b0}};
    end else if ((state == S_HI_WAIT) && data_buf_empty) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Low word capture; the FIFO data is valid the cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_word <= {FIFO_WORD_W{1'b0}};
    end else if (!flush && (state == S_LO_CAP)) begin
      lo_word <= data_word;
    end
  end

  // Timestamp and first-flag output registers, loaded with the high word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_reg       <= {TS_W{1'b0}};
      ts_first_reg <= 1'b1;
    end else if (hi_cap) begin
      ts_reg       <= {data_word, lo_word};
      ts_first_reg <= first_pend;
    end
  end

  // Delivery history: previous timestamp, first flag and accepted count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ts    <= {TS_W{1'b0}};
      first_pend <= 1'b1;
      trig_count <= {TRIG_COUNT_W{1'b0}};
    end else if (flush) begin
      prev_ts    <= {TS_W{1'b0}};
      first_pend <= 1'b1;
      trig_count <= {TRIG_COUNT_W{1'b0}};
    end else if (hs) begin
      prev_ts    <= ts_reg;
      first_pend <= 1'b0;
      trig_count <= sat_inc(trig_count);
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_timeout <= 1'b0;
      order_err    <= 1'b0;
    end else if (flush) begin
      pair_timeout <= 1'b0;
      order_err    <= 1'b0;
    end else begin
      if (hi_expire) begin
        pair_timeout <= 1'b1;
      end
      if (order_pulse) begin
        order_err <= 1'b1;
      end
    end
  end

  shim_ts_delta #(
    .DELTA_WIDTH(DELTA_WIDTH)
  ) u_delta (
    .clk         (clk),
    .rst         (rst),
    .en          (hi_cap),
    .first       (first_pend),
    .cur         ({data_word, lo_word}),
    .prev        (prev_ts),
    .delta       (delta),
    .order_pulse (order_pulse)
  );

  assign ts_out.ts_valid   = (state == S_OUT);
  assign ts_out.ts         = ts_reg;
  assign ts_out.ts_delta   = delta;
  assign ts_out.ts_first   = ts_first_reg;
  assign ts_out.trig_count = trig_count;

endmodule

// File: tb/tb_shim_trigger_ts_reader.sv
// Bench for shim_trigger_ts_reader: a non-FWFT FIFO model feeds word pairs,
// a reference model computes expected timestamps into a scoreboard queue.
module tb_shim_trigger_ts_reader;
  import shim_trigger_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        data_word_rd_en;
  logic [31:0] data_word = 32'd0;
  logic        data_buf_empty = 1'b1;
  logic        pair_timeout;
  logic        order_err;

  shim_trigger_ts_reader_if #(.DELTA_WIDTH(32)) tsif ();

  shim_trigger_ts_reader #(.PAIR_TIMEOUT(16), .DELTA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_word_rd_en (data_word_rd_en),
    .data_word       (data_word),
    .data_buf_empty  (data_buf_empty),
    .flush           (flush),
    .ts_out          (tsif),
    .pair_timeout    (pair_timeout),
    .order_err       (order_err)
  );

  typedef struct {
    logic [63:0] ts;
    logic [31:0] delta;
    logic        first;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] push_q[$];
  int          total = 0;
  int          bad = 0;
  int          underflow = 0;
  logic [63:0] m_prev = 64'd0;
  logic        m_first = 1'b1;

  always #5 clk = ~clk;

  // Non-FWFT FIFO model: data appears the cycle after rd_en, writes land one edge late.
  always @(posedge clk) begin
    if (data_word_rd_en) begin
      if (fifo_q.size() > 0) data_word <= fifo_q.pop_front();
      else underflow <= underflow + 1;
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    data_buf_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_words(input logic [63:0] t);
    push_q.push_back(t[31:0]);
    push_q.push_back(t[63:32]);
  endtask

  task automatic expect_ts(input logic [63:0] t);
    exp_t e;
    logic [63:0] d;
    e.ts    = t;
    e.first = m_first;
    d = t - m_prev;
    if (m_first || (t <= m_prev)) e.delta = 32'd0;
    else if (d > 64'h0000_0000_FFFF_FFFF) e.delta = 32'hFFFF_FFFF;
    else e.delta = d[31:0];
    exp_q.push_back(e);
    m_prev  = t;
    m_first = 1'b0;
  endtask

  task automatic model_flush();
    m_prev  = 64'd0;
    m_first = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_valid(input int budget, output int waited, output bit seen);
    seen = 1'b0;
    waited = 0;
    while (!seen && (waited < budget)) begin
      @(negedge clk);
      waited++;
      if (tsif.ts_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    total++; if (data_word_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", data_word_rd_en); end
    total++; if (tsif.ts_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tsif.ts_valid); end
    total++; if (tsif.ts !== 64'd0) begin bad++; $display("FAIL reset_ts: got %h want 0", tsif.ts); end
    total++; if (tsif.ts_delta !== 32'd0) begin bad++; $display("FAIL reset_delta: got %h want 0", tsif.ts_delta); end
    total++; if (tsif.ts_first !== 1'b1) begin bad++; $display("FAIL reset_first: got %b want 1", tsif.ts_first); end
    total++; if (tsif.trig_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %h want 0", tsif.trig_count); end
    total++; if ({pair_timeout, order_err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {pair_timeout, order_err}); end
  endtask

  task automatic test_first_latency();
    int n; int lat; bit seen; exp_t e;
    push_words(64'd0);
    expect_ts(64'd0);
    n = 0;
    while (!data_word_rd_en && (n < 10)) begin @(negedge clk); n++; end
    total++; if (data_word_rd_en !== 1'b1) begin bad++; $display("FAIL first_rd_en: got %b want 1", data_word_rd_en); end
    wait_valid(10, lat, seen);
    total++; if (!seen || (lat != 3)) begin bad++; $display("FAIL first_latency: got %0d (seen %b) want 3", lat, seen); end
    e = exp_q.pop_front();
    total++; if (tsif.ts !== e.ts) begin bad++; $display("FAIL first_ts: got %h want %h", tsif.ts, e.ts); end
    total++; if (tsif.ts_delta !== e.delta) begin bad++; $display("FAIL first_delta: got %h want %h", tsif.ts_delta, e.delta); end
    total++; if (tsif.ts_first !== e.first) begin bad++; $display("FAIL first_flag: got %b want %b", tsif.ts_first, e.first); end
    @(negedge clk);
    total++; if (tsif.trig_count !== 32'd1) begin bad++; $display("FAIL first_count: got %h want 1", tsif.trig_count); end
  endtask

  task automatic test_back_to_back();
    int w; bit seen; exp_t e;
    logic [63:0] vals [3];
    vals[0] = 64'h1388; vals[1] = 64'h1388; vals[2] = 64'h2000;
    for (int i = 0; i < 3; i++) begin push_words(vals[i]); expect_ts(vals[i]); end
    for (int i = 0; i < 3; i++) begin
      wait_valid(12, w, seen);
      e = exp_q.pop_front();
      total++; if (!seen) begin bad++; $display("FAIL b2b_timeout: item %0d never valid", i); end
      if (i > 0) begin
        total++; if (w != 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", w); end
      end
      total++; if (tsif.ts !== e.ts) begin bad++; $display("FAIL b2b_ts: got %h want %h", tsif.ts, e.ts); end
      total++; if (tsif.ts_delta !== e.delta) begin bad++; $display("FAIL b2b_delta: got %h want %h", tsif.ts_delta, e.delta); end
      total++; if (tsif.ts_first !== e.first) begin bad++; $display("FAIL b2b_first: got %b want %b", tsif.ts_first, e.first); end
    end
    @(negedge clk);
    total++; if (tsif.trig_count !== 32'd4) begin bad++; $display("FAIL b2b_count: got %h want 4", tsif.trig_count); end
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL b2b_order: got %b want 0", order_err); end
  endtask

  task automatic test_saturate();
    int w; bit seen; exp_t e;
    do_flush();
    total++; if (tsif.trig_count !== 32'd0) begin bad++; $display("FAIL sat_flush_count: got %h want 0", tsif.trig_count); end
    push_words(64'h10); expect_ts(64'h10);
    push_words(64'h1_FFFF_FFF0); expect_ts(64'h1_FFFF_FFF0);
    for (int i = 0; i < 2; i++) begin
      wait_valid(12, w, seen);
      e = exp_q.pop_front();
      total++; if (!seen || (tsif.ts !== e.ts)) begin bad++; $display("FAIL sat_ts: got %h want %h", tsif.ts, e.ts); end
      total++; if (tsif.ts_delta !== e.delta) begin bad++; $display("FAIL sat_delta: got %h want %h", tsif.ts_delta, e.delta); end
      total++; if (tsif.ts_first !== e.first) begin bad++; $display("FAIL sat_first: got %b want %b", tsif.ts_first, e.first); end
    end
    @(negedge clk);
    total++; if (tsif.trig_count !== 32'd2) begin bad++; $display("FAIL sat_count: got %h want 2", tsif.trig_count); end
  endtask

  task automatic test_order();
    int w; bit seen; exp_t e;
    do_flush();
    push_words(64'h100); expect_ts(64'h100);
    push_words(64'h80);  expect_ts(64'h80);
    for (int i = 0; i < 2; i++) begin
      wait_valid(12, w, seen);
      e = exp_q.pop_front();
      total++; if (!seen || (tsif.ts !== e.ts)) begin bad++; $display("FAIL order_ts: got %h want %h", tsif.ts, e.ts); end
      total++; if (tsif.ts_delta !== e.delta) begin bad++; $display("FAIL order_delta: got %h want %h", tsif.ts_delta, e.delta); end
      if (i == 0) begin
        total++; if (order_err !== 1'b0) begin bad++; $display("FAIL order_early: got %b want 0", order_err); end
      end
    end
    @(negedge clk);
    total++; if (order_err !== 1'b1) begin bad++; $display("FAIL order_err: got %b want 1", order_err); end
    total++; if (tsif.trig_count !== 32'd2) begin bad++; $display("FAIL order_count: got %h want 2", tsif.trig_count); end
  endtask

  task automatic test_timeout();
    int n; int w; int rd_seen; int v_seen; bit seen; exp_t e;
    logic [63:0] t;
    t = 64'h0000_ABCD_0000_1234;
    do_flush();
    total++; if (order_err !== 1'b0) begin bad++; $display("FAIL to_flush_order: got %b want 0", order_err); end
    push_q.push_back(32'h0000_5555);
    n = 0;
    while (!data_word_rd_en && (n < 10)) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    total++; if (pair_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", pair_timeout); end
    n = 0;
    while (!pair_timeout && (n < 40)) begin @(negedge clk); n++; end
    total++; if (pair_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", pair_timeout); end
    push_words(t);
    rd_seen = 0; v_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_word_rd_en) rd_seen++;
      if (tsif.ts_valid) v_seen++;
    end
    total++; if ((rd_seen != 0) || (v_seen != 0)) begin bad++; $display("FAIL to_stuck: got rd %0d valid %0d want 0 0", rd_seen, v_seen); end
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (data_word_rd_en !== 1'b0) begin bad++; $display("FAIL to_flush_rd: got %b want 0", data_word_rd_en); end
    total++; if (pair_timeout !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", pair_timeout); end
    flush = 1'b0;
    model_flush();
    expect_ts(t);
    wait_valid(12, w, seen);
    e = exp_q.pop_front();
    total++; if (!seen || (tsif.ts !== e.ts)) begin bad++; $display("FAIL to_ts: got %h want %h", tsif.ts, e.ts); end
    total++; if ((tsif.ts_first !== e.first) || (tsif.ts_delta !== e.delta)) begin bad++; $display("FAIL to_first: got %b/%h want %b/%h", tsif.ts_first, tsif.ts_delta, e.first, e.delta); end
    @(negedge clk);
    total++; if (tsif.trig_count !== 32'd1) begin bad++; $display("FAIL to_count: got %h want 1", tsif.trig_count); end
  endtask

  task automatic test_stall_flush();
    int w; bit seen; exp_t e;
    logic [63:0] t2; logic [63:0] t3;
    t2 = 64'h0000_ABCD_0000_2000;
    t3 = 64'h0000_0000_0000_0777;
    tsif.ts_ready = 1'b0;
    push_words(t2); expect_ts(t2);
    push_words(t3);
    wait_valid(12, w, seen);
    e = exp_q.pop_front();
    total++; if (!seen || (tsif.ts !== e.ts) || (tsif.ts_delta !== e.delta) || (tsif.ts_first !== e.first)) begin
      bad++; $display("FAIL stall_out: got %h/%h/%b want %h/%h/%b", tsif.ts, tsif.ts_delta, tsif.ts_first, e.ts, e.delta, e.first);
    end
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ((tsif.ts_valid !== 1'b1) || (tsif.ts !== e.ts) || (tsif.ts_delta !== e.delta) || (tsif.ts_first !== e.first) || (data_word_rd_en !== 1'b0)) begin
        bad++; $display("FAIL stall_hold: cycle %0d got v%b %h/%h/%b rd%b want v1 %h/%h/%b rd0", c, tsif.ts_valid, tsif.ts, tsif.ts_delta, tsif.ts_first, data_word_rd_en, e.ts, e.delta, e.first);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    tsif.ts_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
    total++; if (tsif.ts_valid !== 1'b0) begin bad++; $display("FAIL stall_flush_valid: got %b want 0", tsif.ts_valid); end
    total++; if (tsif.trig_count !== 32'd0) begin bad++; $display("FAIL stall_flush_count: got %h want 0", tsif.trig_count); end
    expect_ts(t3);
    wait_valid(12, w, seen);
    e = exp_q.pop_front();
    total++; if (!seen || (tsif.ts !== e.ts) || (tsif.ts_first !== e.first) || (tsif.ts_delta !== e.delta)) begin
      bad++; $display("FAIL stall_next: got %h/%h/%b want %h/%h/%b", tsif.ts, tsif.ts_delta, tsif.ts_first, e.ts, e.delta, e.first);
    end
    @(negedge clk);
    total++; if (tsif.trig_count !== 32'd1) begin bad++; $display("FAIL stall_next_count: got %h want 1", tsif.trig_count); end
  endtask

  initial begin
    tsif.ts_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_latency();
    test_back_to_back();
    test_saturate();
    test_order();
    test_timeout();
    test_stall_flush();
    repeat (2) @(negedge clk);
    total++; if (underflow != 0) begin bad++; $display("FAIL underflow: got %0d want 0", underflow); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shim_trigger_ts_reader.md
# shim_trigger_ts_reader

Drains the trigger timestamp FIFO filled by the trigger core and reassembles each low/high 32-bit word pair into one 64-bit trigger timestamp. Each timestamp is presented on a valid/ready stream with the saturated interval since the previous trigger and a running trigger count. Sticky error flags cover pairing timeouts and non-monotonic timestamps. Sits between the trigger data FIFO read port and the PS-side readout logic.

## Interface
- `PAIR_TIMEOUT`, 16: max cycles to wait for the high word after the low word is consumed (≥1).
- `DELTA_WIDTH`, 32: width of `ts_delta` (1..64).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high; single clock domain.
- `data_word_rd_en`  out  1  FIFO read strobe; data valid the cycle after (non-FWFT).
- `data_word`  in  32  FIFO read data.
- `data_buf_empty`  in  1  FIFO empty.
- `flush`  in  1  abort partial pair, clear history, counters and error flags.
- `ts_valid`  out  1  timestamp available.
- `ts_ready`  in  1  consumer accepts.
- `ts`  out  64  reassembled timestamp: {high word, low word}.
- `ts_delta`  out  DELTA_WIDTH  `ts` − previous accepted `ts`, saturated.
- `ts_first`  out  1  first timestamp since reset/flush; `ts_delta` = 0.
- `trig_count`  out  32  accepted timestamps, saturating.
- `pair_timeout`  out  1  sticky: high word missing.
- `order_err`  out  1  sticky: `ts` < previous.

## Operation
- FIFO order: low word, then high word, always paired.
- States:
  - S_LO: if `!data_buf_empty`, assert `data_word_rd_en` and go to S_LO_CAP.
  - S_LO_CAP: capture low word. If `!data_buf_empty`, read and go to S_HI_CAP; else go to S_HI_WAIT with timer = 0.
  - S_HI_WAIT: if `!data_buf_empty`, read and go to S_HI_CAP. Else increment the timer; at `PAIR_TIMEOUT` set `pair_timeout` and go to S_ERROR.
  - S_HI_CAP: capture high word, register `ts`, `ts_delta`, `ts_first`; go to S_OUT.
  - S_OUT: `ts_valid` = 1. On `ts_ready`: `prev_ts` ← `ts`, increment `trig_count`, clear first flag, go to S_LO.
  - S_ERROR: no reads, `ts_valid` = 0; exit only via `flush`.
- `data_word_rd_en` is asserted only when `!data_buf_empty` and only in S_LO, S_LO_CAP and S_HI_WAIT.
- Delta rules:
  - `ts` > `prev_ts`: difference, clamped to 2^DELTA_WIDTH−1.
  - Equal (writer timer saturated): 0, no error.
  - `ts` < `prev_ts`: `ts_delta` = 0, set `order_err`; the timestamp is still delivered.
- `trig_count` holds at 0xFFFFFFFF.
- `flush` has top priority and is synchronous, effective the next cycle:
  - next state S_LO; first flag set; `prev_ts` = 0; `trig_count` = 0; both sticky flags cleared.
  - An outstanding read word returning in the flush cycle+1 is discarded, as is a pending S_OUT timestamp.
  - No `data_word_rd_en` in the flush cycle.

## Timing
- Reset values:
  - `data_word_rd_en`, `ts_valid`, `pair_timeout`, `order_err` = 0.
  - `ts`, `ts_delta`, `trig_count` = 0.
  - `ts_first` = 1; state S_LO.
- Latency: the first `rd_en` (cycle 0) gives `ts_valid` at cycle 3 when the FIFO is non-empty throughout.
- Throughput: 4 cycles per timestamp with `ts_ready` held high. This matches the writer's minimum 4-cycle trigger lockout, so the FIFO never grows under sustained triggering.
- `ts`, `ts_delta`, `ts_first` are stable while `ts_valid && !ts_ready`. `ts_valid` does not drop without a handshake except on `flush` or reset.
- Reset mid-pair: the partial pair is lost; the FIFO itself is reset by the same system reset.
- `flush` and `ts_ready` in the same cycle: flush wins; no count increment.

## Structure
- Shared package `shim_trigger_pkg`: state enum; FIFO word width (32); timestamp width (64); trigger lockout minimum (4), shared with the trigger core.
- One natural sub-module, `shim_ts_delta`: registered subtract, compare and saturate (`ts`, `prev_ts` → `ts_delta`, `order_err` pulse). Everything else is inline in the FSM.

## Test plan
- FIFO preloaded with {0x0000_0000, 0x0000_0000}, `ts_ready`=1 → `ts`=0, `ts_first`=1, `ts_delta`=0, `trig_count`=1 after handshake.
- Follow with {0x0000_1388, 0x0000_0000} → `ts`=0x1388, `ts_delta`=0x1388, `ts_first`=0; pair-to-pair spacing 4 cycles.
- Low word 0xFFFF_FFF0/high 0x1, after `prev_ts`=0x10, with `DELTA_WIDTH`=32 → `ts_delta`=0xFFFF_FFFF (saturated).
- Low word only, FIFO empty for 16 cycles → `pair_timeout`=1 and S_ERROR, no further `rd_en`; `flush` → flags 0, next pair read normally with `ts_first`=1.
- `ts`=0x100 then `ts`=0x80 → second delivered with `ts_delta`=0 and `order_err`=1.
- `ts_ready`=0 for 10 cycles in S_OUT → outputs stable, no `rd_en`; `flush` asserted at cycle 5 → `ts_valid`=0 next cycle, `trig_count`=0.
